// File: rtl/max_pool_2x2_4_channel_if.sv
// max_pool_2x2_4_channel_if: 4-channel pixel stream into the pooler and pooled pixel stream out.
interface max_pool_2x2_4_channel_if #(parameter int Datawidth = 32);
    logic valid_in;
    logic signed [Datawidth-1:0] In_0, In_1, In_2, In_3;
    logic valid_out;
    logic frame_done;
    logic signed [Datawidth-1:0] Out_0, Out_1, Out_2, Out_3;
    modport master (
        output valid_in, In_0, In_1, In_2, In_3,
        input  valid_out, frame_done, Out_0, Out_1, Out_2, Out_3
    );
    modport slave (
        input  valid_in, In_0, In_1, In_2, In_3,
        output valid_out, frame_done, Out_0, Out_1, Out_2, Out_3
    );
endinterface

// File: rtl/max_pool_2x2_4_channel.sv
// max_pool_2x2_4_channel: streaming 2x2 stride-2 signed max pooling over 4 channels,
// keeping only a half-width line buffer of top-row maxima.
module max_pool_2x2_4_channel #(
    parameter int IMG_Width  = 4,
    parameter int IMG_Height = 4,
    parameter int Datawidth  = 32
) (
    input logic clk,
    input logic rst,
    max_pool_2x2_4_channel_if.slave bus
);
    localparam int PW = IMG_Width / 2;
    localparam int PH = IMG_Height / 2;
    localparam int CW = $clog2(IMG_Width);
    localparam int RW = $clog2(IMG_Height);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic signed [Datawidth-1:0] din [4];
    logic signed [Datawidth-1:0] pair [4];
    logic signed [Datawidth-1:0] hmax [4];
    logic signed [Datawidth-1:0] top [4];
    logic signed [Datawidth-1:0] vmax [4];
    logic signed [Datawidth-1:0] out [4];
    logic signed [Datawidth-1:0] line_buf [PW][4];
    logic active, col_last, row_last, win_end, valid_r, done_r;

    always_comb begin
        din = '{bus.In_0, bus.In_1, bus.In_2, bus.In_3};
        active = bus.valid_in && int'(col) < 2 * PW && int'(row) < 2 * PH;
        col_last = col == CW'(IMG_Width - 1);
        row_last = row == RW'(IMG_Height - 1);
        win_end = active && col[0] && row[0];
        top = '{default: '0};
        for (int i = 0; i < PW; i++)
            if (CW'(i) == col >> 1) top = line_buf[i];
        for (int c = 0; c < 4; c++) begin
            hmax[c] = din[c] > pair[c] ? din[c] : pair[c];
            vmax[c] = top[c] > hmax[c] ? top[c] : hmax[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col     <= '0;
            row     <= '0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            pair    <= '{default: '0};
            out     <= '{default: '0};
        end else begin
            valid_r <= win_end;
            done_r  <= win_end && int'(col) == 2 * PW - 1 && int'(row) == 2 * PH - 1;
            if (bus.valid_in) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) row <= row_last ? '0 : row + 1'b1;
            end
            if (active && !col[0]) pair <= din;
            if (win_end) out <= vmax;
        end
    end

    // Every entry is written on a top row before the bottom row reads it, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PW; i++)
            if (active && col[0] && !row[0] && CW'(i) == col >> 1) line_buf[i] <= hmax;
    end

    assign bus.valid_out  = valid_r;
    assign bus.frame_done = done_r;
    assign bus.Out_0 = out[0];
    assign bus.Out_1 = out[1];
    assign bus.Out_2 = out[2];
    assign bus.Out_3 = out[3];
endmodule
